// File: rtl/ram_3_pkg.sv
// ram_3_pkg -- shared constants and helpers for the ram_3 scratch memory.
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default address and word widths (10 / 8).
//   DEPTH                   : default word count, 2**ADDR_W_DEF.
//   access_e                : decoded cs/write access kind.
//   even_parity()           : even-parity bit of a word. It is used only when
//                             RAM3_PARITY_EN is defined.
package ram_3_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH      = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_e;

    // The argument is wide enough for any supported word. Callers
    // zero-extend their word, which leaves the XOR reduction unchanged.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_3_array.sv
// ram_3_array -- plain storage array for ram_3.
// The write is synchronous and the read is asynchronous.
// The array has no reset: its contents survive rst. The validity of each
// word is tracked by the top level.
//
// Ports:
//   clk     : write clock (rising edge).
//   i_we    : write enable. It is already qualified by cs, write and rst.
//   i_addr  : word address.
//   i_wdata : write word.
//   o_rdata : combinational read of the word at i_addr.
module ram_3_array #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int unsigned WORDS = 1 << ADDR_W;

    logic [WORD_W-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_3.sv
// ram_3 -- single-port 2**ADDR_W x DATA_W RAM with chip select.
// The write is synchronous and the read is asynchronous.
// Reset clears a per-word valid bit instead of clearing the storage itself.
// A word that was never written, or that was written before the last reset,
// reads as zero.
//
// Optional feature, selected by the macro RAM3_PARITY_EN:
//   Each word stores an even-parity bit alongside its data.
//   parity_err is raised on a read of a valid word whose stored parity bit
//   disagrees with its stored data.
//
// Ports:
//   clk        : clock; writes happen on the rising edge.
//   rst        : asynchronous, active-high. It clears all valid bits and
//                blocks writes.
//   cs         : chip select. The block is idle when cs is low.
//   write      : 1 = write cycle, 0 = read cycle; qualified by cs.
//   address    : word address.
//   data_in    : write data.
//   data_out   : read data. It is 0 unless cs=1, write=0 and the word is valid.
//   parity_err : parity mismatch on read. Present only with RAM3_PARITY_EN.
module ram_3
    import ram_3_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
`ifdef RAM3_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int unsigned WORDS = 1 << ADDR_W;
`ifdef RAM3_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    access_e           w_access;
    logic              w_we;
    logic              w_rd_hit;
    logic [WORD_W-1:0] w_wr_word;
    logic [WORD_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_data;
    logic [WORDS-1:0]  r_valid;

    always_comb begin
        w_access = ACC_IDLE;
        if (cs) begin
            w_access = write ? ACC_WRITE : ACC_READ;
        end
    end

    // rst gates the enable combinationally. A write that coincides with an
    // asserted reset therefore never reaches the array.
    assign w_we     = (w_access == ACC_WRITE) && !rst;
    assign w_rd_hit = (w_access == ACC_READ) && r_valid[address];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_we) begin
            r_valid[address] <= 1'b1;
        end
    end

`ifdef RAM3_PARITY_EN
    assign w_wr_word = {even_parity(64'(data_in)), data_in};
`else
    assign w_wr_word = data_in;
`endif

    ram_3_array #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (address),
        .i_wdata (w_wr_word),
        .o_rdata (w_rd_word)
    );

    assign w_rd_data = w_rd_word[DATA_W-1:0];
    assign data_out  = w_rd_hit ? w_rd_data : '0;

`ifdef RAM3_PARITY_EN
    assign parity_err = w_rd_hit && (w_rd_word[DATA_W] != even_parity(64'(w_rd_data)));
`endif

endmodule

// File: tb/tb_ram_3.sv
module tb_ram_3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       write;
    logic [9:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
`ifdef RAM3_PARITY_EN
    logic       parity_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_3 #(
        .ADDR_W (10),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .write    (write),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
`ifdef RAM3_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        cs      = 1'b1;
        write   = 1'b1;
        address = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [9:0] a, input logic [7:0] expected);
        @(negedge clk);
        cs      = 1'b1;
        write   = 1'b0;
        address = a;
        #1;
        check(tag, data_out, expected);
    endtask

    initial begin
        rst     = 1'b1;
        cs      = 1'b0;
        write   = 1'b0;
        address = '0;
        data_in = '0;
        #1;
        check("reset_idle_out", data_out, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        rd_check("reset_rd_0", 10'd0, 8'h00);
        rd_check("reset_rd_511", 10'd511, 8'h00);
        rd_check("reset_rd_1023", 10'd1023, 8'h00);

        for (int k = 0; k < 1024; k++) begin
            wr(10'(k), 8'((2 * k) % 256));
        end
        rd_check("fill_rd_5", 10'd5, 8'd10);
        rd_check("fill_rd_200", 10'd200, 8'd144);
        rd_check("fill_rd_1023", 10'd1023, 8'd254);
        rd_check("fill_rd_128", 10'd128, 8'd0);

        // A deselected access and a write cycle must both output zero.
        @(negedge clk);
        cs      = 1'b0;
        write   = 1'b0;
        address = 10'd5;
        #1;
        check("cs_low_out", data_out, 8'h00);
        cs      = 1'b1;
        write   = 1'b1;
        data_in = 8'd10;
        #1;
        check("write_cycle_out", data_out, 8'h00);
        @(posedge clk);
        #1;
        rd_check("rd_5_after_wr", 10'd5, 8'd10);

        // Assert reset between clock edges.
        @(negedge clk);
        cs    = 1'b0;
        write = 1'b0;
        #2;
        rst     = 1'b1;
        cs      = 1'b1;
        address = 10'd200;
        #1;
        check("rst_async_rd_200", data_out, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_check("post_rst_rd_200", 10'd200, 8'h00);
        rd_check("post_rst_rd_1023", 10'd1023, 8'h00);
        wr(10'd200, 8'hA5);
        rd_check("rd_200_a5", 10'd200, 8'hA5);
        rd_check("rd_201_invalid", 10'd201, 8'h00);

        wr(10'd3, 8'h11);
        wr(10'd3, 8'h22);
        rd_check("last_write_wins", 10'd3, 8'h22);

        // Reset is held across the edge of a write cycle, so that write is dropped.
        @(negedge clk);
        cs      = 1'b1;
        write   = 1'b1;
        address = 10'd4;
        data_in = 8'h33;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_check("rst_drops_write", 10'd4, 8'h00);
        rd_check("rst_clears_3", 10'd3, 8'h00);
        wr(10'd4, 8'h44);
        rd_check("first_write_after_rst", 10'd4, 8'h44);

`ifdef RAM3_PARITY_EN
        wr(10'd9, 8'h07);
        rd_check("par_rd_9", 10'd9, 8'h07);
        check("par_ok", {7'd0, parity_err}, 8'h00);
        dut.u_array.r_mem[9][0] = ~dut.u_array.r_mem[9][0];
        #1;
        check("par_err_flip", {7'd0, parity_err}, 8'h01);
        check("par_flip_data", data_out, 8'h06);
        @(negedge clk);
        cs = 1'b0;
        #1;
        check("par_idle", {7'd0, parity_err}, 8'h00);
`endif

        @(negedge clk);
        cs = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
